apb_timer_slave: RTL

APB completer (responder) exposing a 32-bit prescaled down-counter timer with sticky expiry flag and interrupt output. Attaches to the APB master bridge as an additional slave select alongside GPIO and UART, using the same 5-bit address and 32-bit data buses. Implements the responder side of the SETUP/ACCESS handshake, including optional wait-state insertion via PREADY.

---
 rtl/apb_timer_slave.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/apb_timer_slave.sv
// ---------------------------------------------------------------------------
// apb_timer_slave
//
// APB completer wrapping a 32-bit prescaled down-counter timer. It shares the
// bridge's 5-bit address and 32-bit data buses with the other peripherals.
//
// Register map (byte addresses, word aligned):
//   0x00 CTRL   : bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, bits[15:8] PRESCALE
//   0x04 LOAD   : reload value; a write also copies the value into COUNT
//   0x08 COUNT  : current counter value (read-only)
//   0x0C STATUS : bit0 EXPIRED, sticky, write 1 to clear
//   Any other address reads 0 and ignores writes.
//
// Ports:
//   PCLK     in   APB clock, all state changes on its rising edge
//   PRESETn  in   asynchronous active-low reset
//   PSEL     in   slave select from the bridge
//   PENABLE  in   access-phase indicator
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   [4:0] byte address
//   PWDATA   in   [31:0] write data
//   PREADY   out  transfer-complete handshake
//   PRDATA   out  [31:0] read data, non-zero only while a read completes
//   irq      out  registered EXPIRED & IRQ_EN
//   state    out  [1:0] APB FSM state: 0 IDLE, 1 SETUP, 2 ACCESS
//
// Configuration:
//   APB_TIMER_WAIT_EN  when defined, every ACCESS phase is stretched by
//                      WAIT_CYCLES (0..15) extra cycles with PREADY low.
//                      When undefined there is no wait counter, PREADY rises
//                      on the first ACCESS cycle and WAIT_CYCLES is ignored.
// ---------------------------------------------------------------------------
`default_nettype none

module apb_timer_slave #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [4:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic        PREADY,
  output logic [31:0] PRDATA,
  output logic        irq,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam logic [4:0] AddrCtrl   = 5'h00;
  localparam logic [4:0] AddrLoad   = 5'h04;
  localparam logic [4:0] AddrCount  = 5'h08;
  localparam logic [4:0] AddrStatus = 5'h0C;

  apb_state_t  fsm;

  // Timer state
  logic        en;
  logic        auto_reload;
  logic        irq_en;
  logic [7:0]  prescale;
  logic [31:0] load_val;
  logic [31:0] count;
  logic        expired;
  logic [7:0]  pre_cnt;

  logic        tick;
  logic        expire_now;
  logic        wr_commit;
  logic        wr_ctrl;
  logic        wr_load;
  logic        wr_status;
  logic [31:0] rd_mux;

  assign state = fsm;

  // ---------------------------------------------------------------------------
  // Wait-state generation. The counter is loaded as the FSM enters ACCESS, so
  // PREADY stays low for exactly WAIT_CYCLES ACCESS cycles.
  // ---------------------------------------------------------------------------
`ifdef APB_TIMER_WAIT_EN
  localparam logic [3:0] WaitLoad = (WAIT_CYCLES > 15) ? 4'd15 : 4'(WAIT_CYCLES);

  logic [3:0] wait_cnt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt <= 4'd0;
    end else if (!PSEL) begin
      wait_cnt <= 4'd0;
    end else if ((fsm == SETUP) && PENABLE) begin
      wait_cnt <= WaitLoad;
    end else if ((fsm == ACCESS) && (wait_cnt != 4'd0)) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  assign PREADY = (fsm == ACCESS) && (wait_cnt == 4'd0);
`else
  assign PREADY = (fsm == ACCESS);
`endif

  // ---------------------------------------------------------------------------
  // APB responder FSM. Losing PSEL in any state aborts back to IDLE; since a
  // write only commits while PSEL is high, an aborted transfer never touches
  // the registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      fsm <= IDLE;
    end else if (!PSEL) begin
      fsm <= IDLE;
    end else begin
      case (fsm)
        IDLE: begin
          if (!PENABLE) fsm <= SETUP;
        end
        SETUP: begin
          if (PENABLE) fsm <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) fsm <= PENABLE ? IDLE : SETUP;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  // A write completes on the single edge where the handshake closes; PREADY
  // is only high in ACCESS, which the FSM leaves on that same edge.
  assign wr_commit = PSEL && PENABLE && PREADY && PWRITE;
  assign wr_ctrl   = wr_commit && (PADDR == AddrCtrl);
  assign wr_load   = wr_commit && (PADDR == AddrLoad);
  assign wr_status = wr_commit && (PADDR == AddrStatus);

  // Prescaler tick and expiry are both derived from the pre-edge register
  // values, so a CTRL write landing on a tick edge does not affect that tick.
  assign tick       = en && (pre_cnt == prescale);
  assign expire_now = tick && (count == 32'd0);

  // ---------------------------------------------------------------------------
  // Prescaler: free-runs while enabled, wraps on tick, and restarts whenever
  // the timer is disabled or LOAD is rewritten.
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pre_cnt <= 8'd0;
    end else if (wr_load || !en || tick) begin
      pre_cnt <= 8'd0;
    end else begin
      pre_cnt <= pre_cnt + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Counter and reload value. A LOAD write takes priority over a coincident
  // tick, so the new value appears without being decremented.
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      load_val <= 32'd0;
      count    <= 32'd0;
    end else begin
      if (wr_load) begin
        load_val <= PWDATA;
      end
      if (wr_load) begin
        count <= PWDATA;
      end else if (tick) begin
        if (count != 32'd0) begin
          count <= count - 32'd1;
        end else if (auto_reload) begin
          count <= load_val;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control register. A one-shot expiry turns the timer off, but an explicit
  // CTRL write on the same edge still takes effect.
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      en          <= 1'b0;
      auto_reload <= 1'b0;
      irq_en      <= 1'b0;
      prescale    <= 8'd0;
    end else if (wr_ctrl) begin
      en          <= PWDATA[0];
      auto_reload <= PWDATA[1];
      irq_en      <= PWDATA[2];
      prescale    <= PWDATA[15:8];
    end else if (expire_now && !auto_reload) begin
      en <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky expiry flag and registered interrupt. A new expiry beats a clear
  // arriving on the same edge so no event is lost.
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      expired <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (expire_now) begin
        expired <= 1'b1;
      end else if (wr_status && PWDATA[0]) begin
        expired <= 1'b0;
      end
      irq <= expired && irq_en;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path. The mux shows the registers as they are before the commit edge;
  // the bus only sees it while a read is actually completing.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_mux = 32'd0;
    case (PADDR)
      AddrCtrl:   rd_mux = {16'd0, prescale, 5'd0, irq_en, auto_reload, en};
      AddrLoad:   rd_mux = load_val;
      AddrCount:  rd_mux = count;
      AddrStatus: rd_mux = {31'd0, expired};
      default:    rd_mux = 32'd0;
    endcase
  end

  assign PRDATA = (PREADY && !PWRITE) ? rd_mux : 32'd0;

endmodule

`default_nettype wire
